mux_scan_ctrl: RTL and testbench

- Sequencer that drives the select lines of the 4:1 mux and consumes its output.
- It steps sel1/sel0 through channels 0..3 and waits a programmable settle time on each channel. It then samples y into a 4-bit snapshot and publishes the snapshot with a one-cycle valid pulse.
- It sits directly around the 4:1 mux: upstream on the select lines, downstream on y.

---
 rtl/mux_scan_ctrl_pkg.sv | 17 +
 rtl/mux_scan_ctrl_if.sv | 28 ++
 rtl/mux_scan_ctrl_settle_timer.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 118 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizing for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned TIMER_W = 4;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control, select and snapshot signals between the scan sequencer and its environment.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic              start;
  logic              continuous;
  logic              y_in;
  logic              sel1;
  logic              sel0;
  logic [NUM_CH-1:0] snapshot;
  logic              valid;
  logic              busy;
  logic [CNT_W-1:0]  scan_count;

  modport master (
    output start, continuous, y_in,
    input  sel1, sel0, snapshot, valid, busy, scan_count
  );

  modport slave (
    input  start, continuous, y_in,
    output sel1, sel0, snapshot, valid, busy, scan_count
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter; zero flags expiry of the per-channel settle interval.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, waits for settling, samples y
// into a snapshot and publishes it with a one-cycle valid pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-2:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TIMER_W'(SETTLE_CYCLES)),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // ch doubles as the registered select: 0 in IDLE, held at 3 through DONE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ch_d     = '0;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (ch_q == LAST_CH) begin
          snap_d  = {bus.y_in, shadow_q};
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = DONE;
        end else begin
          for (int k = 0; k < int'(NUM_CH) - 1; k++) begin
            if (ch_q == SEL_W'(k)) shadow_d[k] = bus.y_in;
          end
          ch_d     = ch_q + SEL_W'(1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        ch_d = '0;
        if (bus.continuous) begin
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sel1       = ch_q[1];
  assign bus.sel0       = ch_q[0];
  assign bus.snapshot   = snap_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.scan_count = cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a SETTLE_CYCLES=2/CNT_W=8 instance and a
// SETTLE_CYCLES=0/CNT_W=2 instance, each wrapped by a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_ctrl_if #(.CNT_W(8)) bus_a ();
  mux_scan_ctrl_if #(.CNT_W(2)) bus_b ();

  logic [3:0] mux_a;
  logic [3:0] mux_b;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign sel_a      = {bus_a.sel1, bus_a.sel0};
  assign sel_b      = {bus_b.sel1, bus_b.sel0};
  assign bus_a.y_in = mux_a[sel_a];
  assign bus_b.y_in = mux_b[sel_b];

  mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus_a.start      = 1'b0;
    bus_a.continuous = 1'b0;
    bus_b.start      = 1'b0;
    bus_b.continuous = 1'b0;
    mux_a            = 4'h0;
    mux_b            = 4'h0;
    tick();
    tick();
    checks++;
    if ({sel_a, bus_a.snapshot, bus_a.valid, bus_a.busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a_outputs got sel=%b snap=%b valid=%b busy=%b exp all 0",
               sel_a, bus_a.snapshot, bus_a.valid, bus_a.busy);
    end
    checks++;
    if (bus_a.scan_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_a_count got %0d exp 0", bus_a.scan_count);
    end
    checks++;
    if ({sel_b, bus_b.snapshot, bus_b.valid, bus_b.busy, bus_b.scan_count} !== 10'h000) begin
      errors++;
      $display("FAIL reset_b_outputs got sel=%b snap=%b valid=%b busy=%b cnt=%0d exp all 0",
               sel_b, bus_b.snapshot, bus_b.valid, bus_b.busy, bus_b.scan_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // One scan of 4'h5 with a per-cycle trace of sel, valid and busy.
  task automatic test_single_scan();
    logic [1:0] exp_sel;
    mux_a       = 4'h5;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) tick();
      exp_sel = (k < 16) ? 2'(k / 4) : ((k == 16) ? 2'd3 : 2'd0);
      checks++;
      if (sel_a !== exp_sel) begin
        errors++;
        $display("FAIL single_sel k=%0d got %b exp %b", k, sel_a, exp_sel);
      end
      checks++;
      if (bus_a.valid !== (k == 16)) begin
        errors++;
        $display("FAIL single_valid k=%0d got %b exp %b", k, bus_a.valid, (k == 16));
      end
      checks++;
      if (bus_a.busy !== (k <= 16)) begin
        errors++;
        $display("FAIL single_busy k=%0d got %b exp %b", k, bus_a.busy, (k <= 16));
      end
      if (k == 16) begin
        checks++;
        if (bus_a.snapshot !== 4'b0101) begin
          errors++;
          $display("FAIL single_snapshot got %b exp 0101", bus_a.snapshot);
        end
        checks++;
        if (bus_a.scan_count !== 8'd1) begin
          errors++;
          $display("FAIL single_count got %0d exp 1", bus_a.scan_count);
        end
      end
    end
  endtask

  // Two back-to-back scans; mux inputs change between them.
  task automatic test_continuous();
    mux_a            = 4'hA;
    bus_a.continuous = 1'b1;
    bus_a.start      = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      checks++;
      if (bus_a.valid !== (k == 16 || k == 33)) begin
        errors++;
        $display("FAIL cont_valid k=%0d got %b exp %b", k, bus_a.valid, (k == 16 || k == 33));
      end
      if (k == 16) begin
        checks++;
        if (bus_a.snapshot !== 4'b1010 || bus_a.scan_count !== 8'd2) begin
          errors++;
          $display("FAIL cont_first got snap=%b cnt=%0d exp snap=1010 cnt=2",
                   bus_a.snapshot, bus_a.scan_count);
        end
        mux_a = 4'h3;
      end
      if (k == 17) begin
        checks++;
        if (bus_a.busy !== 1'b1 || sel_a !== 2'b00) begin
          errors++;
          $display("FAIL cont_restart got busy=%b sel=%b exp busy=1 sel=00", bus_a.busy, sel_a);
        end
        bus_a.continuous = 1'b0;
      end
      if (k == 33) begin
        checks++;
        if (bus_a.snapshot !== 4'b0011 || bus_a.scan_count !== 8'd3) begin
          errors++;
          $display("FAIL cont_second got snap=%b cnt=%0d exp snap=0011 cnt=3",
                   bus_a.snapshot, bus_a.scan_count);
        end
      end
      if (k == 34) begin
        checks++;
        if (bus_a.busy !== 1'b0) begin
          errors++;
          $display("FAIL cont_stop_busy got %b exp 0", bus_a.busy);
        end
      end
    end
  endtask

  // A start pulse in the middle of a scan must not queue a second scan.
  task automatic test_start_ignored();
    int vcount;
    vcount      = 0;
    mux_a       = 4'h5;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus_a.valid === 1'b1) vcount++;
      if (k == 5) bus_a.start = 1'b1;
      if (k == 6) bus_a.start = 1'b0;
    end
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL ignore_valid_count got %0d exp 1", vcount);
    end
    checks++;
    if (bus_a.scan_count !== 8'd4 || bus_a.snapshot !== 4'b0101) begin
      errors++;
      $display("FAIL ignore_result got cnt=%0d snap=%b exp cnt=4 snap=0101",
               bus_a.scan_count, bus_a.snapshot);
    end
  endtask

  // Reset mid-scan discards the scan; a following scan works normally.
  task automatic test_reset_mid_scan();
    int vcount;
    int bcount;
    vcount      = 0;
    bcount      = 0;
    mux_a       = 4'h6;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_a, bus_a.snapshot, bus_a.valid, bus_a.busy} !== 8'h00 ||
        bus_a.scan_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_outputs got sel=%b snap=%b valid=%b busy=%b cnt=%0d exp all 0",
               sel_a, bus_a.snapshot, bus_a.valid, bus_a.busy, bus_a.scan_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_a.valid === 1'b1) vcount++;
      if (bus_a.busy === 1'b1) bcount++;
    end
    checks++;
    if (vcount !== 0 || bcount !== 0) begin
      errors++;
      $display("FAIL midrst_quiet got valid_cycles=%0d busy_cycles=%0d exp 0 0", vcount, bcount);
    end
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    checks++;
    if (bus_a.valid !== 1'b1 || bus_a.snapshot !== 4'b0110 || bus_a.scan_count !== 8'd1) begin
      errors++;
      $display("FAIL midrst_rescan got valid=%b snap=%b cnt=%0d exp valid=1 snap=0110 cnt=1",
               bus_a.valid, bus_a.snapshot, bus_a.scan_count);
    end
    tick();
  endtask

  // Zero settle time and a 2-bit scan counter that wraps.
  task automatic test_zero_settle_wrap();
    logic [1:0] exp_cnt;
    mux_b = 4'hF;
    for (int s = 1; s <= 5; s++) begin
      exp_cnt     = 2'(s);
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        tick();
        if (k == 7) begin
          checks++;
          if (bus_b.valid !== 1'b0) begin
            errors++;
            $display("FAIL zs_early_valid scan=%0d got %b exp 0", s, bus_b.valid);
          end
        end
        if (k == 8) begin
          checks++;
          if (bus_b.valid !== 1'b1 || bus_b.snapshot !== 4'hF || bus_b.scan_count !== exp_cnt) begin
            errors++;
            $display("FAIL zs_result scan=%0d got valid=%b snap=%h cnt=%0d exp valid=1 snap=f cnt=%0d",
                     s, bus_b.valid, bus_b.snapshot, bus_b.scan_count, exp_cnt);
          end
        end
        if (k == 9) begin
          checks++;
          if (bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL zs_busy scan=%0d got %b exp 0", s, bus_b.busy);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_continuous();
    test_start_ignored();
    test_reset_mid_scan();
    test_zero_settle_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
